// File: rtl/fir_shift_stream.sv
// Streaming FIR with per-tap right-shift weights and a ready/valid output stage.
// Tap 0 is the live input; taps 1..TAPS-1 come from a delay line of accepted samples.
module fir_shift_stream #(
   parameter int DW   = 8,
   parameter int TAPS = 5,
   parameter int SW   = 3,
   parameter int OW   = 11
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] x,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_addr,
   input  logic [SW-1:0] cfg_shift,
   input  logic          cfg_en,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [OW-1:0] dataout,
   output logic          primed
);

   localparam int CW = $clog2(TAPS + 1);

   if (TAPS < 2 || TAPS > 16) begin : g_bad_taps
      $error("fir_shift_stream: TAPS must be in 2..16");
   end
   if (OW < DW + $clog2(TAPS)) begin : g_bad_ow
      $error("fir_shift_stream: OW too narrow for worst-case sum");
   end

   logic [DW-1:0] dl_q [1:TAPS-1];
   logic [DW-1:0] dl_d [1:TAPS-1];
   logic [SW-1:0] sh_q [TAPS];
   logic [SW-1:0] sh_d [TAPS];
   logic [TAPS-1:0] en_q, en_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          vld_q, vld_d;
   logic [OW-1:0] dout_q, dout_d;
   logic [OW-1:0] sum;
   logic [DW-1:0] tap [TAPS];
   logic          acc;

   // Power-on weight: shift by the distance from the far end, capped at the code range.
   function automatic logic [SW-1:0] rst_shift(input int k);
      int lim;
      lim = (1 << SW) - 1;
      return (TAPS - k > lim) ? SW'(lim) : SW'(TAPS - k);
   endfunction

   assign in_ready = !clr && (!vld_q || out_ready);
   assign acc      = in_valid && in_ready;

   always_comb begin
      tap[0] = x;
      for (int k = 1; k < TAPS; k++) tap[k] = dl_q[k];
   end

   // OW is wide enough for TAPS full-scale terms, so the sum cannot wrap.
   always_comb begin
      sum = '0;
      for (int k = 0; k < TAPS; k++) begin
         if (en_q[k]) sum = sum + (OW'(tap[k]) >> sh_q[k]);
      end
   end

   always_comb begin
      dl_d   = dl_q;
      sh_d   = sh_q;
      en_d   = en_q;
      cnt_d  = cnt_q;
      vld_d  = vld_q;
      dout_d = dout_q;
      if (clr) begin
         for (int k = 1; k < TAPS; k++) dl_d[k] = '0;
         cnt_d  = '0;
         vld_d  = 1'b0;
         dout_d = '0;
      end else if (acc) begin
         dl_d[1] = x;
         for (int k = 2; k < TAPS; k++) dl_d[k] = dl_q[k-1];
         if (cnt_q != CW'(TAPS)) cnt_d = cnt_q + CW'(1);
         vld_d  = 1'b1;
         dout_d = sum;
      end else if (out_ready) begin
         vld_d = 1'b0;
      end
      // Config lands on the edge, so a result computed this cycle still sees the old weights.
      for (int k = 0; k < TAPS; k++) begin
         if (cfg_we && int'(cfg_addr) == k) begin
            sh_d[k] = cfg_shift;
            en_d[k] = cfg_en;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 1; k < TAPS; k++) dl_q[k] <= '0;
         for (int k = 0; k < TAPS; k++) sh_q[k] <= rst_shift(k);
         en_q   <= '1;
         cnt_q  <= '0;
         vld_q  <= 1'b0;
         dout_q <= '0;
      end else begin
         dl_q   <= dl_d;
         sh_q   <= sh_d;
         en_q   <= en_d;
         cnt_q  <= cnt_d;
         vld_q  <= vld_d;
         dout_q <= dout_d;
      end
   end

   assign out_valid = vld_q;
   assign dataout   = dout_q;
   assign primed    = (cnt_q == CW'(TAPS));

endmodule
